// File: rtl/pe_pkg.sv
// Shared PE encodings: mode codes, command op codes and controller state codes.
// Also used by the PE and the array top.
package pe_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_SAVE   = 2'd1;
  localparam logic [1:0] MODE_SA     = 2'd2;
  localparam logic [1:0] MODE_INIT   = 2'd3;

  localparam logic [1:0] OP_SINGLE  = 2'd0;
  localparam logic [1:0] OP_LOAD    = 2'd1;
  localparam logic [1:0] OP_SA      = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_RUN_SA  = 3'd2;
  localparam state_t ST_RUN_SGL = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

endpackage

// File: rtl/pe_ctrl_dly.sv
// Valid shift register of parameterised depth.
// It lines up tagged fire events with the PE output register.
module pe_ctrl_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/pe_ctrl.sv
// Command sequencer for the PE datapath. Optional perf counters: PE_CTRL_PERF_EN.
// state      | meaning
// IDLE       | ready for a command, PE holds (mode 3)
// LOAD       | pacing save beats (mode 1)
// RUN_SA     | pacing systolic beats (mode 2, activate)
// RUN_SGL    | pacing single-PE accumulate beats (mode 0)
// DRAIN      | waiting PIPE_LAT+1 cycles for the PE chain, then done
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int PIPE_LAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       mode_o,
  output logic             activate_o,
  output logic             res_valid_o,
  output logic             done_o,
  output logic             err_o
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_busy_o,
  output logic [31:0]      perf_stall_o
`endif
);

  localparam int DLY_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [DLY_W-1:0] dly;
  logic             err_q;
  logic             fire;
  logic             last;
  logic             res_tag;

  assign cmd_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_LOAD) || (state == ST_RUN_SA) || (state == ST_RUN_SGL);
  assign fire      = in_ready && in_valid;
  assign last      = fire && (cnt == len_q);
  assign res_tag   = fire && ((state == ST_RUN_SA) || ((state == ST_RUN_SGL) && last));
  assign done_o    = (state == ST_DRAIN) && (dly == '0);
  assign err_o     = done_o && err_q;

  // A stalled beat drops to MODE_INIT so every PE register holds.
  always_comb begin
    mode_o     = MODE_INIT;
    activate_o = 1'b0;
    if (in_valid) begin
      case (state)
        ST_LOAD:    mode_o = MODE_SAVE;
        ST_RUN_SA: begin
          mode_o     = MODE_SA;
          activate_o = 1'b1;
        end
        ST_RUN_SGL: mode_o = MODE_SINGLE;
        default:    mode_o = MODE_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      len_q <= '0;
      cnt   <= '0;
      dly   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            len_q <= cmd_len;
            cnt   <= '0;
            dly   <= DLY_W'(PIPE_LAT);
            err_q <= (cmd_op == OP_ILLEGAL);
            case (cmd_op)
              OP_LOAD:   state <= ST_LOAD;
              OP_SA:     state <= ST_RUN_SA;
              OP_SINGLE: state <= ST_RUN_SGL;
              default:   state <= ST_DRAIN;
            endcase
          end
        end
        ST_LOAD, ST_RUN_SA, ST_RUN_SGL: begin
          if (last) begin
            state <= ST_DRAIN;
            dly   <= DLY_W'(PIPE_LAT);
          end else if (fire) begin
            cnt <= cnt + LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (dly == '0) begin
            state <= ST_IDLE;
            err_q <= 1'b0;
          end else begin
            dly <= dly - DLY_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe_ctrl_dly #(.DEPTH(PIPE_LAT + 1)) u_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (res_tag),
    .dout (res_valid_o)
  );

`ifdef PE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_busy_o  <= '0;
      perf_stall_o <= '0;
    end else begin
      if ((state != ST_IDLE) && (perf_busy_o != 32'hFFFF_FFFF))
        perf_busy_o <= perf_busy_o + 32'd1;
      if (in_ready && !in_valid && (perf_stall_o != 32'hFFFF_FFFF))
        perf_stall_o <= perf_stall_o + 32'd1;
    end
  end
`endif

endmodule
